// File: rtl/scroll_lane_move.sv
// scroll_lane_move: one shared speed FSM scrolling NUM_OBJ staggered objects in fixed point.
// Optional macro SCROLL_JITTER_EN adds LFSR jitter to the wrap reload height.
module scroll_lane_move #(
  parameter int NUM_OBJ      = 4,
  parameter int FRAC_BITS    = 6,
  parameter int INITIAL_Y    = 310,
  parameter int OBJ_SPACING  = 160,
  parameter int FRAME_BOTTOM = 479,
  parameter int WRAP_Y       = -500,
  parameter int MAX_SPEED    = 230,
  parameter int ACCEL        = 20,
  parameter int BRAKE        = 42,
  parameter int DRAG         = 18,
  parameter int BOOST_STEP   = 100,
  parameter int BOOST_PULSES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   startOfFrame,
  input  logic                   slow_pulse,
  input  logic                   fast_pulse,
  input  logic                   move_allow,
  input  logic                   restart_enable,
  input  logic                   up_is_pressed,
  input  logic                   down_is_pressed,
  input  logic                   enter_is_pressed,
  output logic [NUM_OBJ*11-1:0]  topLeftY,
  output logic [7:0]             speed,
  output logic [NUM_OBJ-1:0]     wrapped,
  output logic                   boosting
);

  // state    | meaning
  // ST_IDLE  | stopped, speed == 0
  // ST_ACCEL | gas held on last slow_pulse
  // ST_COAST | no pedal, speed bleeding off by DRAG
  // ST_BRAKE | brake held on last slow_pulse
  // ST_BOOST | boost burst, boost_cnt fast_pulse steps still pending
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ACCEL = 3'd1;
  localparam logic [2:0] ST_COAST = 3'd2;
  localparam logic [2:0] ST_BRAKE = 3'd3;
  localparam logic [2:0] ST_BOOST = 3'd4;

  localparam int CNT_W = $clog2(BOOST_PULSES + 1);
  localparam logic signed [31:0] BOTTOM_FP = 32'(FRAME_BOTTOM * (2 ** FRAC_BITS));
  localparam logic signed [31:0] WRAP_FP   = 32'(WRAP_Y * (2 ** FRAC_BITS));
  localparam logic signed [31:0] BOOST_FP  = 32'(BOOST_STEP * (2 ** FRAC_BITS));

  logic [2:0]         state, state_nxt;
  logic [CNT_W-1:0]   boost_cnt, boost_cnt_nxt;
  logic [7:0]         speed_nxt;
  logic [9:0]         speed_up;
  logic               sof_q, slow_q, fast_q, boost_step;
  logic signed [31:0] pos     [NUM_OBJ];
  logic signed [31:0] pos_sum [NUM_OBJ];
  logic signed [31:0] pos_nxt [NUM_OBJ];
  logic [NUM_OBJ-1:0] wrap_nxt;
  logic signed [31:0] frame_inc, boost_inc, reload_fp;

  // move_allow gates every strobe, so held state falls out naturally
  assign sof_q      = startOfFrame & move_allow;
  assign slow_q     = slow_pulse & move_allow;
  assign fast_q     = fast_pulse & move_allow;
  assign boost_step = fast_q && (state == ST_BOOST);
  assign boosting   = (state == ST_BOOST);

  always_comb begin
    speed_up  = {2'b00, speed} + 10'(ACCEL);
    speed_nxt = speed;
    if (slow_q) begin
      if (up_is_pressed)
        speed_nxt = (speed_up >= 10'(MAX_SPEED)) ? 8'(MAX_SPEED) : speed_up[7:0];
      else if (down_is_pressed)
        speed_nxt = (speed > 8'(BRAKE)) ? speed - 8'(BRAKE) : 8'd0;
      else
        speed_nxt = (speed > 8'(DRAG)) ? speed - 8'(DRAG) : 8'd0;
    end
  end

  always_comb begin
    state_nxt     = state;
    boost_cnt_nxt = boost_cnt;
    if (slow_q && (state != ST_BOOST)) begin
      if (up_is_pressed)        state_nxt = ST_ACCEL;
      else if (down_is_pressed) state_nxt = ST_BRAKE;
      else if (speed_nxt == 8'd0) state_nxt = ST_IDLE;
      else                      state_nxt = ST_COAST;
    end
    // a boost request outranks the pedal decision of the same cycle
    if (fast_q) begin
      if (state == ST_BOOST) begin
        boost_cnt_nxt = boost_cnt - 1'b1;
        if (boost_cnt == CNT_W'(1)) state_nxt = ST_COAST;
      end else if (enter_is_pressed) begin
        state_nxt     = ST_BOOST;
        boost_cnt_nxt = CNT_W'(BOOST_PULSES);
      end
    end
  end

`ifdef SCROLL_JITTER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign reload_fp = (32'(WRAP_Y) - {26'd0, lfsr[5:0]}) <<< FRAC_BITS;
`else
  assign reload_fp = WRAP_FP;
`endif

  assign frame_inc = sof_q ? {24'd0, speed} : 32'sd0;
  assign boost_inc = boost_step ? BOOST_FP : 32'sd0;

  // wrap is decided on the next value so an object is never shown below the frame
  always_comb begin
    wrap_nxt = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      pos_sum[i] = pos[i] + frame_inc + boost_inc;
      if (pos_sum[i] > BOTTOM_FP) begin
        pos_nxt[i]  = reload_fp;
        wrap_nxt[i] = 1'b1;
      end else begin
        pos_nxt[i]  = pos_sum[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || restart_enable) begin
      state     <= ST_IDLE;
      speed     <= 8'd0;
      boost_cnt <= '0;
      wrapped   <= '0;
      for (int i = 0; i < NUM_OBJ; i++)
        pos[i] <= 32'((INITIAL_Y - i * OBJ_SPACING) * (2 ** FRAC_BITS));
    end else begin
      state     <= state_nxt;
      speed     <= speed_nxt;
      boost_cnt <= boost_cnt_nxt;
      wrapped   <= wrap_nxt;
      for (int i = 0; i < NUM_OBJ; i++)
        pos[i] <= pos_nxt[i];
    end
  end

  always_comb begin
    topLeftY = '0;
    for (int i = 0; i < NUM_OBJ; i++)
      topLeftY[11*i +: 11] = 11'(pos[i] >>> FRAC_BITS);
  end

endmodule

// File: tb/tb_scroll_lane_move.sv
// Scoreboard bench for scroll_lane_move: expectations are queued as stimulus is driven
// and drained against the DUT outputs one cycle later.
module tb_scroll_lane_move;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            startOfFrame = 1'b0, slow_pulse = 1'b0, fast_pulse = 1'b0;
  logic            move_allow = 1'b1, restart_enable = 1'b0;
  logic            up_is_pressed = 1'b0, down_is_pressed = 1'b0, enter_is_pressed = 1'b0;
  logic [N*11-1:0] topLeftY;
  logic [7:0]      speed;
  logic [N-1:0]    wrapped;
  logic            boosting;

  scroll_lane_move dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .slow_pulse(slow_pulse),
    .fast_pulse(fast_pulse), .move_allow(move_allow), .restart_enable(restart_enable),
    .up_is_pressed(up_is_pressed), .down_is_pressed(down_is_pressed),
    .enter_is_pressed(enter_is_pressed), .topLeftY(topLeftY), .speed(speed),
    .wrapped(wrapped), .boosting(boosting)
  );

  always #5 clk = ~clk;

  // kind: 0 speed, 1 topLeftY[idx], 2 wrapped[idx], 3 boosting
  typedef struct { int kind; int idx; int exp; } exp_t;
  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  // pedal code: 0 none, 1 gas, 2 brake, 3 both
  int ped_tab[34] = '{1,1,1,1,1,1,1,1,1,1,1,1, 0,0,0,0,0,0,0,0,0,0,0,0,0,
                      2, 1,1,1, 2,2, 3, 0,0};
  int spd_tab[34] = '{20,40,60,80,100,120,140,160,180,200,220,230,
                      212,194,176,158,140,122,104,86,68,50,32,14,0,
                      0, 20,40,60, 18,0, 20, 2,0};

  function automatic logic signed [31:0] obs(int kind, int idx);
    case (kind)
      0:       return {24'd0, speed};
      1:       return 32'($signed(topLeftY[11*idx +: 11]));
      2:       return {31'd0, wrapped[idx]};
      default: return {31'd0, boosting};
    endcase
  endfunction

  function automatic string kname(int kind);
    case (kind)
      0:       return "speed";
      1:       return "topLeftY";
      2:       return "wrapped";
      default: return "boosting";
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int kind, int idx, int e);
    exp_t x;
    x.kind = kind; x.idx = idx; x.exp = e;
    sb.push_back(x);
  endtask

  task automatic push_all(int y0, int y1, int y2, int y3, int spd, int bst);
    push(1, 0, y0); push(1, 1, y1); push(1, 2, y2); push(1, 3, y3);
    push(0, 0, spd); push(3, 0, bst);
    for (int i = 0; i < N; i++) push(2, i, 0);
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    push_all(310, 150, -10, -170, 0, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      if (obs(e.kind, e.idx) !== e.exp)
        $display("FAIL reset %s[%0d]: got %0d, expected %0d", kname(e.kind), e.idx, obs(e.kind, e.idx), e.exp);
      else passed++;
    end
  endtask

  task automatic test_speed();
    exp_t e;
    for (int k = 0; k < 34; k++) begin
      up_is_pressed   = ped_tab[k][0];
      down_is_pressed = ped_tab[k][1];
      slow_pulse = 1'b1;
      tick();
      slow_pulse = 1'b0;
      push(0, 0, spd_tab[k]);
      push(3, 0, 0);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        total++;
        if (obs(e.kind, e.idx) !== e.exp)
          $display("FAIL speed step%0d %s: got %0d, expected %0d", k, kname(e.kind), obs(e.kind, e.idx), e.exp);
        else passed++;
      end
    end
    up_is_pressed = 1'b0; down_is_pressed = 1'b0;
  endtask

  task automatic test_scroll();
    exp_t e;
    restart_enable = 1'b1; tick(); restart_enable = 1'b0;
    // 5 gas pulses to 100, then two drag pulses to 64 (exactly 1 px per frame)
    for (int k = 0; k < 7; k++) begin
      up_is_pressed = (k < 5);
      slow_pulse = 1'b1; tick(); slow_pulse = 1'b0;
    end
    up_is_pressed = 1'b0;
    push(0, 0, 64);
    for (int f = 1; f <= 171; f++) begin
      startOfFrame = (f <= 170);
      tick();
      startOfFrame = 1'b0;
      if (f <= 169) begin
        push(1, 0, 310 + f); push(2, 0, 0);
        if (f == 10) begin push(1, 1, 160); push(1, 2, 0); push(1, 3, -160); end
      end else if (f == 170) begin
        push(1, 0, -500); push(2, 0, 1);
        push(1, 1, 320); push(1, 2, 160); push(1, 3, 0);
        push(2, 1, 0); push(2, 2, 0); push(2, 3, 0);
      end else begin
        push(1, 0, -500); push(2, 0, 0); push(0, 0, 64);
      end
      while (sb.size() != 0) begin
        e = sb.pop_front();
        total++;
        if (obs(e.kind, e.idx) !== e.exp)
          $display("FAIL scroll frame%0d %s[%0d]: got %0d, expected %0d", f, kname(e.kind), e.idx, obs(e.kind, e.idx), e.exp);
        else passed++;
      end
    end
  endtask

  task automatic test_boost();
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      enter_is_pressed = (s == 0);
      fast_pulse       = 1'b1;
      startOfFrame     = (s == 2);
      tick();
      fast_pulse = 1'b0; enter_is_pressed = 1'b0; startOfFrame = 1'b0;
      case (s)
        0: push_all(-500, 320, 160, 0, 64, 1);
        1: push_all(-400, 420, 260, 100, 64, 1);
        2: begin
             push(1, 0, -299); push(1, 1, -500); push(1, 2, 361); push(1, 3, 201);
             push(2, 1, 1); push(2, 0, 0); push(3, 0, 1);
           end
        default: push_all(-199, -400, 461, 301, 64, 0);
      endcase
      while (sb.size() != 0) begin
        e = sb.pop_front();
        total++;
        if (obs(e.kind, e.idx) !== e.exp)
          $display("FAIL boost step%0d %s[%0d]: got %0d, expected %0d", s, kname(e.kind), e.idx, obs(e.kind, e.idx), e.exp);
        else passed++;
      end
    end
  endtask

  task automatic test_freeze_restart();
    exp_t e;
    for (int c = 0; c < 52; c++) begin
      if (c < 50) begin
        move_allow       = 1'b0;
        startOfFrame     = 1'($urandom_range(0, 1));
        slow_pulse       = 1'($urandom_range(0, 1));
        fast_pulse       = 1'($urandom_range(0, 1));
        up_is_pressed    = 1'($urandom_range(0, 1));
        down_is_pressed  = 1'($urandom_range(0, 1));
        enter_is_pressed = 1'($urandom_range(0, 1));
      end else begin
        // restart races every strobe in the same cycle
        move_allow     = 1'b1;
        restart_enable = (c == 50);
        startOfFrame   = (c == 50); slow_pulse = (c == 50); fast_pulse = (c == 50);
        up_is_pressed  = (c == 50); enter_is_pressed = (c == 50); down_is_pressed = 1'b0;
      end
      tick();
      startOfFrame = 1'b0; slow_pulse = 1'b0; fast_pulse = 1'b0; restart_enable = 1'b0;
      up_is_pressed = 1'b0; down_is_pressed = 1'b0; enter_is_pressed = 1'b0;
      if (c < 50) push_all(-199, -400, 461, 301, 64, 0);
      else        push_all(310, 150, -10, -170, 0, 0);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        total++;
        if (obs(e.kind, e.idx) !== e.exp)
          $display("FAIL freeze/restart cyc%0d %s[%0d]: got %0d, expected %0d", c, kname(e.kind), e.idx, obs(e.kind, e.idx), e.exp);
        else passed++;
      end
    end
    move_allow = 1'b1;
  endtask

`ifdef SCROLL_JITTER_EN
  task automatic test_jitter();
    int ys[8];
    int nw = 0;
    int cyc = 0;
    int y;
    bit differ = 0;
    restart_enable = 1'b1; tick(); restart_enable = 1'b0;
    up_is_pressed = 1'b1;
    for (int k = 0; k < 12; k++) begin slow_pulse = 1'b1; tick(); slow_pulse = 1'b0; end
    up_is_pressed = 1'b0;
    while (nw < 8 && cyc < 6000) begin
      startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; cyc++;
      for (int i = 0; i < N; i++) begin
        if (wrapped[i] === 1'b1 && nw < 8) begin
          y = int'(obs(1, i));
          total++;
          if (y < -563 || y > -500)
            $display("FAIL jitter reload obj%0d: got %0d, expected in [-563,-500]", i, y);
          else passed++;
          ys[nw] = y;
          nw++;
        end
      end
    end
    total++;
    if (nw < 8) $display("FAIL jitter wrap count: got %0d, expected 8 within budget", nw);
    else passed++;
    for (int j = 1; j < nw; j++) if (ys[j] != ys[0]) differ = 1;
    total++;
    if (!differ) $display("FAIL jitter spread: got all reloads %0d, expected differing values", ys[0]);
    else passed++;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_speed();
`ifdef SCROLL_JITTER_EN
    test_jitter();
`else
    test_scroll();
    test_boost();
    test_freeze_restart();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
